// File: rtl/axi_node_cfg_sequencer.sv
// axi_node_cfg_sequencer: AXI4-Lite master that turns rule/connectivity commands into
//    ordered writes to the axi_node config register bank.
//    A rule update is written as: valid word <- 0, start, end, valid word <- rule_valid.
//    This ordering means the crossbar never decodes a half-updated rule.
//    A connectivity update is a single write of the zero-extended row.
// Optional feature: define CFG_SEQ_READBACK_VERIFY_EN to read back and compare each write.
// Ports:
//    s_axi_aclk, s_axi_aresetn    clock, asynchronous active-low reset
//    cmd_valid / cmd_ready        command handshake
//    cmd_type                     0 = rule update, 1 = connectivity update
//    cmd_region, cmd_master       rule location
//    cmd_slave                    connectivity row index
//    cmd_start_addr, cmd_end_addr rule address range
//    cmd_rule_valid               final valid bit of the rule
//    cmd_conn_map                 connectivity row
//    busy, done, err              status (err is sticky until the next accepted command)
//    m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels
module axi_node_cfg_sequencer #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int N_REGION_MAX = 4,
   parameter int N_MASTER_PORT = 16,
   parameter int N_SLAVE_PORT = 16,
   parameter logic [31:0] CFG_BASE_ADDR = 32'h0,
   localparam int AW = C_M_AXI_ADDR_WIDTH,
   localparam int DW = C_M_AXI_DATA_WIDTH,
   localparam int RW = N_REGION_MAX > 1 ? $clog2(N_REGION_MAX) : 1,
   localparam int MW = N_MASTER_PORT > 1 ? $clog2(N_MASTER_PORT) : 1,
   localparam int SW = N_SLAVE_PORT > 1 ? $clog2(N_SLAVE_PORT) : 1
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_type,
   input  logic [RW-1:0]            cmd_region,
   input  logic [MW-1:0]            cmd_master,
   input  logic [SW-1:0]            cmd_slave,
   input  logic [31:0]              cmd_start_addr,
   input  logic [31:0]              cmd_end_addr,
   input  logic                     cmd_rule_valid,
   input  logic [N_MASTER_PORT-1:0] cmd_conn_map,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [AW-1:0]            m_axi_awaddr,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [DW-1:0]            m_axi_wdata,
   output logic [DW/8-1:0]          m_axi_wstrb,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   output logic [AW-1:0]            m_axi_araddr,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [DW-1:0]            m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
);
   localparam logic [31:0] RULE_STRIDE = 32'(4 * N_REGION_MAX);
   localparam logic [31:0] CONN_BASE = 32'(N_MASTER_PORT * 4 * N_REGION_MAX);
   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
`ifdef CFG_SEQ_READBACK_VERIFY_EN
      RD_ADDR,
      RD_DATA,
`endif
      DONE
   } state_t;
   state_t state, state_n;
   logic c_type, c_valid, aw_done, w_done, err_q;
   logic [RW-1:0] c_region;
   logic [MW-1:0] c_master;
   logic [SW-1:0] c_slave;
   logic [31:0] c_start, c_end;
   logic [N_MASTER_PORT-1:0] c_map;
   logic [1:0] step;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic accept, last, b_err, r_err, next_wr;
   // Step 0..3 of a rule maps to word offsets 2,0,1,2 (disable, start, end, re-enable).
   function automatic logic [31:0] word_of(logic t, logic [RW-1:0] r, logic [MW-1:0] m,
                                           logic [SW-1:0] s, logic [1:0] st);
      logic [1:0] off;
      off = st == 2'd0 ? 2'd2 : st - 2'd1;
      return t ? CONN_BASE + 32'(s) : 32'(r) * 32'd4 + 32'(m) * RULE_STRIDE + 32'(off);
   endfunction
   function automatic logic [31:0] data_of(logic t, logic [31:0] sa, logic [31:0] ea, logic v,
                                           logic [N_MASTER_PORT-1:0] map, logic [1:0] st);
      return t ? 32'(map) : st == 2'd1 ? sa : st == 2'd2 ? ea : st == 2'd3 ? {31'b0, v} : 32'h0;
   endfunction
   function automatic logic [AW-1:0] addr_of(logic [31:0] w);
      return AW'(CFG_BASE_ADDR + (w << 2));
   endfunction
   assign accept = cmd_valid && state == IDLE;
   assign last = c_type || step == 2'd3;
   assign b_err = state == WR_RESP && m_axi_bvalid && m_axi_bresp != 2'b00;
`ifdef CFG_SEQ_READBACK_VERIFY_EN
   logic r_bad;
   assign r_bad = m_axi_rresp != 2'b00 || m_axi_rdata != data_q;
   assign r_err = state == RD_DATA && m_axi_rvalid && r_bad;
`else
   logic unused_rd;
   assign unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
   assign r_err = 1'b0;
`endif
   // A new write starts whenever we re-enter WR_ADDR_DATA from a response state.
   assign next_wr = state_n == WR_ADDR_DATA && state != WR_ADDR_DATA && state != IDLE;
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:         if (cmd_valid) state_n = WR_ADDR_DATA;
         WR_ADDR_DATA: if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_n = WR_RESP;
`ifdef CFG_SEQ_READBACK_VERIFY_EN
         WR_RESP:      if (m_axi_bvalid) state_n = b_err ? DONE : RD_ADDR;
         RD_ADDR:      if (m_axi_arready) state_n = RD_DATA;
         RD_DATA:      if (m_axi_rvalid) state_n = r_bad || last ? DONE : WR_ADDR_DATA;
`else
         WR_RESP:      if (m_axi_bvalid) state_n = b_err || last ? DONE : WR_ADDR_DATA;
`endif
         default:      state_n = IDLE;
      endcase
   end
   always_comb begin
      cmd_ready = state == IDLE;
      busy = state != IDLE && state != DONE;
      done = state == DONE;
      err = err_q;
      m_axi_awaddr = addr_q;
      m_axi_awvalid = state == WR_ADDR_DATA && !aw_done;
      m_axi_wdata = data_q;
      m_axi_wstrb = '1;
      m_axi_wvalid = state == WR_ADDR_DATA && !w_done;
      m_axi_bready = state == WR_RESP;
`ifdef CFG_SEQ_READBACK_VERIFY_EN
      m_axi_araddr = addr_q;
      m_axi_arvalid = state == RD_ADDR;
      m_axi_rready = state == RD_DATA;
`else
      m_axi_araddr = '0;
      m_axi_arvalid = 1'b0;
      m_axi_rready = 1'b0;
`endif
   end
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         c_type <= 1'b0;
         c_region <= '0;
         c_master <= '0;
         c_slave <= '0;
         c_start <= '0;
         c_end <= '0;
         c_valid <= 1'b0;
         c_map <= '0;
         step <= 2'd0;
         addr_q <= '0;
         data_q <= '0;
         aw_done <= 1'b0;
         w_done <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            c_type <= cmd_type;
            c_region <= cmd_region;
            c_master <= cmd_master;
            c_slave <= cmd_slave;
            c_start <= cmd_start_addr;
            c_end <= cmd_end_addr;
            c_valid <= cmd_rule_valid;
            c_map <= cmd_conn_map;
            step <= 2'd0;
            addr_q <= addr_of(word_of(cmd_type, cmd_region, cmd_master, cmd_slave, 2'd0));
            data_q <= DW'(data_of(cmd_type, cmd_start_addr, cmd_end_addr, cmd_rule_valid, cmd_conn_map, 2'd0));
         end else if (next_wr) begin
            step <= step + 2'd1;
            addr_q <= addr_of(word_of(c_type, c_region, c_master, c_slave, step + 2'd1));
            data_q <= DW'(data_of(c_type, c_start, c_end, c_valid, c_map, step + 2'd1));
         end
         // Each channel's valid drops on its own handshake; both flags clear when the write leaves.
         aw_done <= state == WR_ADDR_DATA && state_n == WR_ADDR_DATA && (aw_done || m_axi_awready);
         w_done <= state == WR_ADDR_DATA && state_n == WR_ADDR_DATA && (w_done || m_axi_wready);
         err_q <= accept ? 1'b0 : err_q || b_err || r_err;
      end
   end
endmodule

// File: tb/tb_axi_node_cfg_sequencer.sv
// tb_axi_node_cfg_sequencer: randomized bench with a behavioural write-list model and AXI-Lite slave
module tb_axi_node_cfg_sequencer;
   localparam int NR = 4, NM = 16, NS = 16;
   localparam logic [31:0] BASE = 32'h0;
`ifdef CFG_SEQ_READBACK_VERIFY_EN
   localparam int PER_WR = 4;
`else
   localparam int PER_WR = 2;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic cmd_valid, cmd_ready, cmd_type, cmd_rule_valid, busy, done, err;
   logic [1:0] cmd_region;
   logic [3:0] cmd_master, cmd_slave;
   logic [31:0] cmd_start_addr, cmd_end_addr;
   logic [15:0] cmd_conn_map;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0] wstrb;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;
   axi_node_cfg_sequencer dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_region(cmd_region), .cmd_master(cmd_master), .cmd_slave(cmd_slave),
      .cmd_start_addr(cmd_start_addr), .cmd_end_addr(cmd_end_addr),
      .cmd_rule_valid(cmd_rule_valid), .cmd_conn_map(cmd_conn_map),
      .busy(busy), .done(done), .err(err),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );
   int checks = 0, errors = 0;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   int aw_lat, w_lat, b_lat, err_at, bad_rd_at;
   int nwr, nrd, nb, aw_hi, w_hi;
   logic [63:0] wlog[$];
   logic [63:0] exp_q[$];
   logic [31:0] mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   // AXI-Lite slave: decisions made on the falling edge take effect at the next rising edge.
   initial begin
      logic [31:0] pa, pd, ra, last_aw;
      bit have_aw, have_w, have_ar, aw_fire, w_fire, ar_fire, b_fire, r_fire, bpend, aw_stall;
      int aw_wait, w_wait, b_wait;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            have_aw = 0; have_w = 0; have_ar = 0; bpend = 0; aw_stall = 0;
            aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0;
            continue;
         end
         if (aw_fire) have_aw = 1;
         if (w_fire) have_w = 1;
         if (ar_fire) have_ar = 1;
         if (b_fire) bvalid = 0;
         if (r_fire) rvalid = 0;
         if (have_aw && have_w) begin
            nwr++;
            wlog.push_back({pa, pd});
            bresp = nwr == err_at ? 2'b10 : 2'b00;
            if (nwr != err_at) mem[pa] = pd;
            have_aw = 0; have_w = 0; bpend = 1; b_wait = 0;
         end
         if (bpend) begin
            if (b_wait >= b_lat) begin bvalid = 1; bpend = 0; end
            else b_wait++;
         end
         if (have_ar) begin
            nrd++;
            rdata = mem.exists(ra) ? mem[ra] : 32'h0;
            if (nrd == bad_rd_at) rdata = rdata ^ 32'h1;
            rresp = 2'b00; rvalid = 1; have_ar = 0;
         end
         if (aw_stall) check("awaddr_stable", awaddr, last_aw);
         if (awvalid) aw_hi++;
         if (wvalid) w_hi++;
         awready = awvalid && aw_wait >= aw_lat;
         wready = wvalid && w_wait >= w_lat;
         aw_fire = awvalid && awready;
         w_fire = wvalid && wready;
         aw_stall = awvalid && !awready;
         last_aw = awaddr;
         aw_wait = aw_stall ? aw_wait + 1 : 0;
         w_wait = wvalid && !wready ? w_wait + 1 : 0;
         if (aw_fire) pa = awaddr;
         if (w_fire) pd = wdata;
         arready = arvalid;
         ar_fire = arvalid && arready;
         if (ar_fire) ra = araddr;
         b_fire = bvalid && bready;
         if (b_fire) nb++;
         r_fire = rvalid && rready;
      end
   end
   function automatic logic [31:0] ba(int w);
      return BASE + 32'(w) * 32'd4;
   endfunction
   // Reference: the ordered list of (address, data) writes a command must produce.
   task automatic build_exp(bit t, int r, int m, int s, logic [31:0] st, logic [31:0] en, bit v, logic [15:0] map);
      int w;
      exp_q.delete();
      if (t) exp_q.push_back({ba(NM * 4 * NR + s), 32'(map)});
      else begin
         w = r * 4 + m * 4 * NR;
         exp_q.push_back({ba(w + 2), 32'h0});
         exp_q.push_back({ba(w), st});
         exp_q.push_back({ba(w + 1), en});
         exp_q.push_back({ba(w + 2), {31'b0, v}});
      end
   endtask
   task automatic apply_ref(int upto);
      for (int k = 0; k < upto; k++) ref_mem[exp_q[k][63:32]] = exp_q[k][31:0];
   endtask
   task automatic drive_cmd(bit t, int r, int m, int s, logic [31:0] st, logic [31:0] en, bit v, logic [15:0] map);
      cmd_type = t; cmd_region = 2'(r); cmd_master = 4'(m); cmd_slave = 4'(s);
      cmd_start_addr = st; cmd_end_addr = en; cmd_rule_valid = v; cmd_conn_map = map;
      cmd_valid = 1;
   endtask
   task automatic run_cmd(bit t, int r, int m, int s, logic [31:0] st, logic [31:0] en, bit v,
                          logic [15:0] map, int al, int wl, int bl, int ea, int rb);
      int n, nexp, nap;
      bit exp_err, busy_ok;
      logic [31:0] a;
      aw_lat = al; w_lat = wl; b_lat = bl; err_at = ea; bad_rd_at = rb;
      build_exp(t, r, m, s, st, en, v, map);
      nexp = exp_q.size(); nap = nexp; exp_err = 0;
      if (ea >= 1 && ea <= nexp) begin nexp = ea; nap = ea - 1; exp_err = 1; end
`ifdef CFG_SEQ_READBACK_VERIFY_EN
      else if (rb >= 1 && rb <= nexp) begin nexp = rb; nap = rb; exp_err = 1; end
`endif
      nwr = 0; nrd = 0; nb = 0; aw_hi = 0; w_hi = 0; wlog.delete();
      n = 0;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      check("ready_before", cmd_ready, 1);
      drive_cmd(t, r, m, s, st, en, v, map);
      n = 0; busy_ok = 1;
      do begin
         tick(); n++;
         if (n == 1) begin
            check("err_cleared", err, 0);
            drive_cmd(~t, $urandom % NR, $urandom % NM, $urandom % NS, $urandom, $urandom, ~v, 16'($urandom));
         end
         if (!done) busy_ok &= busy && !cmd_ready;
      end while (!done && n < 400);
      cmd_valid = 0;
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      check("busy_during", busy_ok, 1);
      check("err", err, exp_err);
      if (al == 0 && wl == 0 && bl == 0 && !exp_err) check("latency", n + 1, 2 + nexp * PER_WR);
      check("nwrites", wlog.size(), nexp);
      check("nbresp", nb, nexp);
      for (int k = 0; k < nexp && k < wlog.size(); k++) begin
         check("wr_addr", wlog[k][63:32], exp_q[k][63:32]);
         check("wr_data", wlog[k][31:0], exp_q[k][31:0]);
      end
      tick();
      check("done_pulse", done, 0);
      check("ready_after", cmd_ready, 1);
      apply_ref(nap);
      for (int k = 0; k < exp_q.size(); k++) begin
         a = exp_q[k][63:32];
         check("mem", mem.exists(a) ? mem[a] : 32'h0, ref_mem.exists(a) ? ref_mem[a] : 32'h0);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      int k;
      cmd_valid = 0; cmd_type = 0; cmd_region = 0; cmd_master = 0; cmd_slave = 0;
      cmd_start_addr = 0; cmd_end_addr = 0; cmd_rule_valid = 0; cmd_conn_map = 0;
      aw_lat = 0; w_lat = 0; b_lat = 0; err_at = 0; bad_rd_at = 0;
      tick(); tick();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("rst_addr_data", {awaddr, araddr, wdata}, 0);
      check("rst_wstrb", wstrb, 4'hF);
      rst_n = 1;
      tick();
      run_cmd(0, 1, 2, 0, 32'h1000_0000, 32'h1000_FFFF, 1, 0, 0, 0, 0, 0, 0);
      check("t1_first_addr", wlog[0][63:32], 32'h98);
      check("t1_last_data", wlog[3][31:0], 32'h1);
      run_cmd(1, 0, 0, 3, 0, 0, 0, 16'h00F5, 0, 0, 0, 0, 0);
      check("t2_addr", wlog[0][63:32], 32'h40C);
      check("t2_data", wlog[0][31:0], 32'h0000_00F5);
      run_cmd(0, 1, 2, 0, 32'h2000_0000, 32'h2000_0FFF, 1, 0, 0, 0, 0, 2, 0);
      check("t3_valid_word", mem[32'h98], 32'h0);
      run_cmd(0, 2, 7, 0, 32'h3000_0000, 32'h3000_FFFF, 1, 0, 2, 0, 0, 0, 0);
      check("t4_aw_cycles", aw_hi, 12);
      check("t4_w_cycles", w_hi, 4);
      build_exp(0, 3, 5, 0, 32'h4000_0000, 32'h4000_FFFF, 1, 0);
      aw_lat = 0; w_lat = 0; b_lat = 1; err_at = 0; bad_rd_at = 0;
      nwr = 0; nrd = 0; wlog.delete();
      drive_cmd(0, 3, 5, 0, 32'h4000_0000, 32'h4000_FFFF, 1, 0);
      tick();
      cmd_valid = 0;
      k = 0;
      while (!(bready && wlog.size() == 3) && k < 100) begin tick(); k++; end
      check("rst_reach_wr3", wlog.size(), 3);
      rst_n = 0;
      #1;
      check("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", cmd_ready, 1);
      tick(); tick();
      rst_n = 1;
      apply_ref(3);
      tick();
      check("rst_rel_ready", cmd_ready, 1);
      check("rst_rel_err", err, 0);
      run_cmd(0, 3, 5, 0, 32'h5000_0000, 32'h5000_FFFF, 0, 0, 0, 0, 0, 0, 0);
`ifdef CFG_SEQ_READBACK_VERIFY_EN
      run_cmd(0, 1, 2, 0, 32'h1000_0000, 32'h1000_FFFF, 1, 0, 0, 0, 0, 0, 3);
      check("t6_valid_word", mem[32'h98], 32'h0);
`endif
      for (int i = 0; i < 40; i++) begin
         int ea, rb;
         ea = $urandom % 5 == 0 ? $urandom_range(1, 4) : 0;
         rb = ea == 0 && $urandom % 5 == 0 ? $urandom_range(1, 4) : 0;
         run_cmd($urandom % 2, $urandom % NR, $urandom % NM, $urandom % NS, $urandom, $urandom,
                 $urandom % 2, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), ea, rb);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_node_cfg_sequencer.md
Name: axi_node_cfg_sequencer

Overview:
AXI4-Lite master that applies routing-rule and connectivity updates to the axi_node configuration register bank.
- Accepts one command at a time on a valid/ready interface.
- Expands each command into an ordered write burst: a rule is disabled, rewritten, then re-enabled, so the crossbar never decodes a half-updated rule.
- Sits between the SoC control processor (or boot ROM sequencer) and the config slave port of axi_node.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI-Lite address width
C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
N_REGION_MAX, 4, regions per master port
N_MASTER_PORT, 16, master ports of the node
N_SLAVE_PORT, 16, slave ports of the node
CFG_BASE_ADDR, 32'h0, byte base address of the config bank

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_type  in  1  0=rule update, 1=connectivity update
cmd_region  in  $clog2(N_REGION_MAX)  region index (rule)
cmd_master  in  $clog2(N_MASTER_PORT)  master port index (rule)
cmd_slave  in  $clog2(N_SLAVE_PORT)  slave port index (connectivity)
cmd_start_addr  in  32  rule start address
cmd_end_addr  in  32  rule end address
cmd_rule_valid  in  1  final valid bit of the rule
cmd_conn_map  in  N_MASTER_PORT  connectivity row, zero-extended to 32
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of sequence
err  out  1  sticky error (bresp!=OKAY or verify mismatch); cleared on next accepted command
m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channels, widths per parameters

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, err=0, all m_axi valid/ready outputs 0, awaddr/araddr/wdata=0, wstrb=4'hF.
- Command capture: on accept, latch all command fields; cmd_ready=0 until the cycle after done. cmd_valid while busy is ignored.
- Word index for a rule: W = region*4 + master*4*N_REGION_MAX. Offsets: +0 start, +1 end, +2 valid.
- Word index for connectivity: C = N_MASTER_PORT*4*N_REGION_MAX + slave.
- Byte address = CFG_BASE_ADDR + word*4.
- Rule write order, strictly sequential:
  1. word W+2 <- 0
  2. W+0 <- start
  3. W+1 <- end
  4. W+2 <- {31'b0, rule_valid}
- Connectivity: a single write to C.
- States: IDLE, WR_ADDR_DATA, WR_RESP, [RD_ADDR, RD_DATA when verify compiled in], DONE.
- WR_ADDR_DATA: awvalid and wvalid asserted in the same cycle. Each drops independently on its own handshake; awaddr/wdata held stable while valid. Go to WR_RESP once both have handshaked, in either order or the same cycle.
- WR_RESP: bready=1. On bvalid:
  - bresp!=2'b00 -> err=1, abort the remaining writes, go to DONE.
  - Otherwise go to the next write, or DONE after the last one.
- DONE: done=1 for one cycle, busy=0 the same cycle, cmd_ready=1 the next cycle, back to IDLE.
- No outstanding transactions beyond one; no address/data reordering.
- Minimum latency for a rule with a zero-wait slave: 4 writes × 2 cycles + accept + DONE = 10 cycles from accept to done.
- Reset mid-sequence: all channels return to reset values immediately; a partially written rule is left as-is (the valid word may be 0). Software re-issues the command.

Optional Feature:
CFG_SEQ_READBACK_VERIFY_EN:
- Defined: after each successful write, RD_ADDR issues araddr = same address with arvalid held until arready. RD_DATA asserts rready=1; on rvalid, compare rdata to the written data.
  - Mismatch or rresp!=OKAY -> err=1, abort, DONE.
  - Rule sequence costs 8 transactions.
- Undefined: read channel outputs are tied to 0 and RD states do not exist.

Test Plan:
- Rule update, region=1, master=2, start=32'h1000_0000, end=32'h1000_FFFF, valid=1, zero-wait slave -> writes in order: 0x98<-0, 0x90<-0x1000_0000, 0x94<-0x1000_FFFF, 0x98<-1; done at cycle 10; err=0.
- Connectivity update, slave=3, map=16'h00F5 -> single write 0x40C<-32'h0000_00F5; done pulse; cmd_ready=1 the next cycle.
- Slave returns bresp=2'b10 on the 2nd write of a rule update -> err=1, no 3rd/4th write issued, done pulses, word 0x98 left 0.
- awready delayed 3 cycles while wready=1 immediately -> wvalid drops after 1 cycle, awvalid held 3 cycles with stable address, a single bready handshake; sequence completes correctly.
- Async reset asserted during WR_RESP of write 3 -> all valids=0, busy=0, cmd_ready=1 after release; a new command executes normally.
- With CFG_SEQ_READBACK_VERIFY_EN, slave corrupts the readback of end (returns 0x1000_FFFE) -> err=1, the valid-word write is skipped, done pulses.
